matrix_spi_rx: RTL and testbench
================================

# matrix_spi_rx

Receive-side decoder for the LED matrix output bus: oversamples the shared SPI clock, the CHANNEL_NUMBER parallel MOSI lines and the column shift-register control lines (ser clock, data, store clock, output enable), and reconstructs the per-channel data words, the latched column select and frame boundaries. It is the counterpart of the output module. It serves as the in-system loopback monitor and as the bench-side checker for the output path, and it is the front end for FPGA-based matrix emulation. All inputs are asynchronous to the block clock and are synchronized internally.

## Interface
Parameters:
- CHANNEL_NUMBER, 3: number of parallel MOSI lines sharing one SPI clock
- SPI_SIZE, 24: bits per word, MSB first
- SHIFT_WIDTH, 16: column shift-register length
- TIMEOUT_CYCLES, 256: idle I_clk cycles that abort a partial word (only with the timeout feature)

Ports:
- I_clk  in  1  block clock; must be at least 6x the SPI clock frequency
- I_rst_n  in  1  synchronous, active-low reset
- I_spi_clk  in  1  SPI clock; idles low; data is valid on the rising edge
- I_spi_mosi  in  CHANNEL_NUMBER  serial data, one line per channel
- I_ser_clk  in  1  shift-register clock; shifts on the rising edge
- I_ser_data  in  1  shift-register serial input
- I_ser_stcp  in  1  store clock; latches on the rising edge
- I_ser_n_enable  in  1  active-low output enable
- O_words  out  CHANNEL_NUMBER x SPI_SIZE  last completed word per channel (unpacked array, index = channel)
- O_word_valid  out  1  one-cycle pulse when O_words updates
- O_word_index  out  8  count of words received since the last column latch, saturating at 255
- O_column  out  SHIFT_WIDTH  latched column pattern
- O_column_index  out  $clog2(SHIFT_WIDTH)  index of the lowest set bit of O_column, 0 if none set
- O_column_valid  out  1  O_column is one-hot
- O_new_image  out  1  one-cycle pulse on a latch that yields O_column == 1
- O_output_enabled  out  1  synchronized, inverted I_ser_n_enable
- O_frame_error  out  1  one-cycle pulse on a timeout abort

## Operation
- Every input passes through a 2-FF synchronizer. Edges are detected between synchronizer stage 2 and a third registered copy. MOSI is taken from stage 2 on the same cycle the SPI rising edge is detected.
- On an SPI rising edge:
  - each channel shifts its register as sh[c] <= {sh[c][SPI_SIZE-2:0], mosi[c]}
  - bit_cnt increments
- When bit_cnt reaches SPI_SIZE:
  - the shift registers are copied to O_words and O_word_valid pulses
  - bit_cnt returns to 0
  - O_word_index increments, saturating at 255
- Column path:
  - on an I_ser_clk rising edge: col_sh <= {col_sh[SHIFT_WIDTH-2:0], ser_data}
  - on an I_ser_stcp rising edge: O_column <= col_sh, O_word_index <= 0, and O_column_index / O_column_valid are recomputed from the new value
- Simultaneous ser_clk and stcp edges: the latch captures col_sh before the shift (74HC595 semantics).
- Simultaneous stcp latch and word completion: O_word_index becomes 1, so the completed word counts toward the new column.
- Falling edges of every input are ignored.

## Timing
- Reset values: O_words all zero, O_column 0, O_column_index 0, O_word_index 0; every pulse output low; O_column_valid 0; O_output_enabled 0. Internal shift registers, bit_cnt and the idle counter are cleared.
- Reset mid-word discards the partial word. The first word after reset starts at bit 0.
- Latency from an input edge at the pins to the registered output is 4 I_clk cycles: 2 synchronizer cycles, 1 detect cycle, 1 output register cycle. This applies to O_word_valid after the final SPI rising edge, to O_column after an stcp edge, and to O_output_enabled.
- SPI high and low phases must each last at least 3 I_clk cycles. Shorter phases are outside specification and may cause missed bits.
- O_new_image and O_frame_error pulse on the same cycle O_column updates, or the cycle the timeout fires, respectively.

## Configuration
- Macro: MATRIX_SPI_RX_TIMEOUT_EN.
- Defined:
  - an idle counter counts I_clk cycles without an SPI rising edge while bit_cnt != 0
  - on reaching TIMEOUT_CYCLES: bit_cnt is cleared, O_frame_error pulses for one cycle, and O_words is left unchanged
  - the counter resets on every SPI edge and whenever bit_cnt == 0
- Not defined: no idle counter is built, O_frame_error is tied to 0, and a partial word waits indefinitely for its remaining bits.

## Test plan
- Reset, then one 24-bit word 0xA5C3F0 on channel 0 (channels 1 and 2 held at 0), SPI at I_clk/8 -> single O_word_valid pulse 4 cycles after the last rising edge; O_words[0]=0xA5C3F0, O_words[1]=O_words[2]=0, O_word_index=1.
- Three channels carry 0x123456, 0xABCDEF and 0xFFFFFF; eight consecutive words -> 8 valid pulses, every word matches, O_word_index reads 8.
- Shift ser_data=1 once, then stcp -> O_column=0x0001, O_column_index=0, O_column_valid=1, one O_new_image pulse, O_word_index=0. Then 5 shifts of 0 and stcp -> O_column=0x0020, index 5, no new_image.
- ser_clk and stcp rising in the same sample with col_sh=0x0004 and ser_data=0 -> O_column=0x0004, col_sh becomes 0x0008.
- MATRIX_SPI_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=256: send 10 bits, idle 300 cycles -> one O_frame_error pulse 256 cycles after the last edge, no O_word_valid. Next full word 0x00FF00 is received correctly. With the macro undefined, the same stimulus combines the 10 stale bits with the first 14 bits of the next word.
- Assert I_rst_n low after 12 bits for 1 cycle -> all outputs return to reset values. A following word 0x5A5A5A decodes exactly.

Source files
------------

// File: rtl/matrix_spi_rx.sv
// matrix_spi_rx: oversampling decoder for the LED matrix SPI + column shift-register bus; MATRIX_SPI_RX_TIMEOUT_EN adds a partial-word idle timeout
module matrix_spi_rx #(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE       = 24,
  parameter int SHIFT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic                           I_spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]      I_spi_mosi,
  input  logic                           I_ser_clk,
  input  logic                           I_ser_data,
  input  logic                           I_ser_stcp,
  input  logic                           I_ser_n_enable,
  output logic [SPI_SIZE-1:0]            O_words [CHANNEL_NUMBER],
  output logic                           O_word_valid,
  output logic [7:0]                     O_word_index,
  output logic [SHIFT_WIDTH-1:0]         O_column,
  output logic [$clog2(SHIFT_WIDTH)-1:0] O_column_index,
  output logic                           O_column_valid,
  output logic                           O_new_image,
  output logic                           O_output_enabled,
  output logic                           O_frame_error
);
  localparam int N  = CHANNEL_NUMBER + 5;
  localparam int CW = $clog2(SPI_SIZE + 1);
  localparam int IW = $clog2(SHIFT_WIDTH);
  localparam int SPI = CHANNEL_NUMBER;
  localparam int SCK = CHANNEL_NUMBER + 1;
  localparam int SDA = CHANNEL_NUMBER + 2;
  localparam int STC = CHANNEL_NUMBER + 3;
  localparam int NEN = CHANNEL_NUMBER + 4;
  localparam logic [N-1:0] RST_V = {1'b1, {(N-1){1'b0}}};
  logic [N-1:0] s1, s2;
  logic [3:0] s3;
  logic [2:0] cur, rise;
  logic [SPI_SIZE-1:0] sh [CHANNEL_NUMBER];
  logic [CW-1:0] bit_cnt;
  logic [SHIFT_WIDTH-1:0] col_sh, col_pend;
  logic latch_q, word_done, one_hot, timeout_fire;
  logic [IW-1:0] idx;
  assign cur = {s2[STC], s2[SCK], s2[SPI]};
  assign rise = cur & ~s3[2:0];
  assign word_done = bit_cnt == CW'(SPI_SIZE);
  assign one_hot = col_pend != '0 && (col_pend & (col_pend - 1'b1)) == '0;
  always_comb begin
    idx = '0;
    for (int i = SHIFT_WIDTH - 1; i >= 0; i--)
      if (col_pend[i]) idx = IW'(i);
  end
  // the store clock snapshots col_sh in the detect cycle, ahead of any concurrent shift
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      s1 <= RST_V;
      s2 <= RST_V;
      s3 <= 4'b1000;
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        sh[c] <= '0;
        O_words[c] <= '0;
      end
      bit_cnt <= '0;
      col_sh <= '0;
      col_pend <= '0;
      latch_q <= 1'b0;
      O_word_valid <= 1'b0;
      O_word_index <= '0;
      O_column <= '0;
      O_column_index <= '0;
      O_column_valid <= 1'b0;
      O_new_image <= 1'b0;
      O_output_enabled <= 1'b0;
    end else begin
      s1 <= {I_ser_n_enable, I_ser_stcp, I_ser_data, I_ser_clk, I_spi_clk, I_spi_mosi};
      s2 <= s1;
      s3 <= {s2[NEN], cur};
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        if (rise[0]) sh[c] <= {sh[c][SPI_SIZE-2:0], s2[c]};
        if (word_done) O_words[c] <= sh[c];
      end
      bit_cnt <= timeout_fire ? '0 : (word_done ? '0 : bit_cnt) + CW'(rise[0]);
      O_word_valid <= word_done;
      if (rise[1]) col_sh <= {col_sh[SHIFT_WIDTH-2:0], s2[SDA]};
      latch_q <= rise[2];
      if (rise[2]) col_pend <= col_sh;
      if (latch_q) begin
        O_column <= col_pend;
        O_column_index <= idx;
        O_column_valid <= one_hot;
      end
      O_new_image <= latch_q && col_pend == SHIFT_WIDTH'(1);
      O_word_index <= latch_q ? 8'(word_done) :
                      (word_done && O_word_index != 8'hff) ? O_word_index + 8'd1 : O_word_index;
      O_output_enabled <= ~s3[3];
    end
  end
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle;
  logic spi_edge;
  assign spi_edge = cur[0] ^ s3[0];
  assign timeout_fire = bit_cnt != '0 && !spi_edge && idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      idle <= '0;
      O_frame_error <= 1'b0;
    end else begin
      idle <= (bit_cnt == '0 || spi_edge || timeout_fire) ? '0 : idle + 1'b1;
      O_frame_error <= timeout_fire;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign O_frame_error = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_spi_rx.sv
// tb_matrix_spi_rx: table-driven bench with a word scoreboard for matrix_spi_rx
module tb_matrix_spi_rx;
  localparam int C = 3, W = 24, SW = 16;
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif
  typedef logic [3*W-1:0] w3_t;
  typedef struct {
    logic [W-1:0] d [3];
    bit rst_before;
    logic [7:0] idx;
  } wvec_t;
  typedef struct {
    logic bit_v;
    int n;
    logic [SW-1:0] col;
    logic [3:0] idx;
    logic vld;
    int ni;
  } cvec_t;
  logic I_clk = 0, I_rst_n = 0, I_spi_clk = 0, I_ser_clk = 0, I_ser_data = 0, I_ser_stcp = 0, I_ser_n_enable = 1;
  logic [C-1:0] I_spi_mosi = '0;
  logic [W-1:0] O_words [C];
  logic O_word_valid, O_column_valid, O_new_image, O_output_enabled, O_frame_error;
  logic [7:0] O_word_index;
  logic [SW-1:0] O_column;
  logic [3:0] O_column_index;
  w3_t exp_q [$];
  w3_t got_w, exp_w;
  int n_cmp = 0, n_bad = 0, cyc = 0, valid_cnt = 0, valid_cyc = 0, ni_cnt = 0, fe_cnt = 0, fe_cyc = 0;
  int last_rise = 0, last_edge = 0;
  wvec_t wv [9];
  cvec_t cv [7];
  matrix_spi_rx dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_spi_clk(I_spi_clk), .I_spi_mosi(I_spi_mosi),
    .I_ser_clk(I_ser_clk), .I_ser_data(I_ser_data), .I_ser_stcp(I_ser_stcp), .I_ser_n_enable(I_ser_n_enable),
    .O_words(O_words), .O_word_valid(O_word_valid), .O_word_index(O_word_index), .O_column(O_column),
    .O_column_index(O_column_index), .O_column_valid(O_column_valid), .O_new_image(O_new_image),
    .O_output_enabled(O_output_enabled), .O_frame_error(O_frame_error)
  );
  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;
  always @(negedge I_clk) begin
    if (O_new_image) ni_cnt++;
    if (O_frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (O_word_valid) begin
      got_w = {O_words[2], O_words[1], O_words[0]};
      valid_cnt++;
      valid_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL word_unexpected: got %h, no word expected", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          n_bad++;
          $display("FAIL word: got %h expected %h", got_w, exp_w);
        end
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge I_clk);
  endtask
  task automatic send(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2, input int n, input bit latch_last);
    for (int b = W - 1; b >= W - n; b--) begin
      I_spi_mosi = {d2[b], d1[b], d0[b]};
      I_spi_clk = 0;
      last_edge = cyc;
      tick(4);
      I_spi_clk = 1;
      last_rise = cyc;
      if (latch_last && b == W - n) I_ser_stcp = 1;
      tick(4);
    end
    I_spi_clk = 0;
    I_ser_stcp = 0;
    last_edge = cyc;
    tick(6);
  endtask
  task automatic shift(input logic b);
    I_ser_data = b;
    tick(3);
    I_ser_clk = 1;
    tick(3);
    I_ser_clk = 0;
  endtask
  task automatic latch();
    I_ser_stcp = 1;
    tick(3);
    I_ser_stcp = 0;
    tick(4);
  endtask
  task automatic reset_pulse(input int n);
    I_rst_n = 0;
    tick(n);
    for (int c = 0; c < C; c++) check($sformatf("rst_word%0d", c), O_words[c], 0);
    check("rst_column", O_column, 0);
    check("rst_column_index", O_column_index, 0);
    check("rst_column_valid", O_column_valid, 0);
    check("rst_word_index", O_word_index, 0);
    check("rst_pulses", {O_word_valid, O_new_image, O_frame_error}, 0);
    check("rst_output_enabled", O_output_enabled, 0);
    I_rst_n = 1;
    tick(2);
  endtask
  initial begin
    logic [W-1:0] base_v [3];
    logic [W-1:0] nw;
    logic [9:0] stale;
    int v0, f0, n0, t0;
    base_v = '{24'h123456, 24'hABCDEF, 24'hFFFFFF};
    wv[0].d = '{24'hA5C3F0, 24'h0, 24'h0};
    wv[0].rst_before = 0;
    wv[0].idx = 1;
    for (int i = 1; i < 9; i++) begin
      for (int c = 0; c < C; c++) wv[i].d[c] = base_v[(c + i) % 3];
      wv[i].rst_before = (i == 1);
      wv[i].idx = 8'(i);
    end
    cv[0] = '{1'b1, 1, 16'h0001, 4'd0, 1'b1, 1};
    cv[1] = '{1'b0, 5, 16'h0020, 4'd5, 1'b1, 0};
    cv[2] = '{1'b1, 1, 16'h0041, 4'd0, 1'b0, 0};
    cv[3] = '{1'b0, 16, 16'h0000, 4'd0, 1'b0, 0};
    cv[4] = '{1'b1, 1, 16'h0001, 4'd0, 1'b1, 1};
    cv[5] = '{1'b1, 15, 16'hFFFF, 4'd0, 1'b0, 0};
    cv[6] = '{1'b0, 15, 16'h8000, 4'd15, 1'b1, 0};
    reset_pulse(3);
    I_ser_n_enable = 0;
    t0 = cyc;
    tick(3);
    check("oe_before_latency", O_output_enabled, 0);
    tick(1);
    check("oe_latency", {O_output_enabled, 8'(cyc - t0)}, {1'b1, 8'd4});
    for (int i = 0; i < 9; i++) begin
      if (wv[i].rst_before) reset_pulse(1);
      v0 = valid_cnt;
      exp_q.push_back({wv[i].d[2], wv[i].d[1], wv[i].d[0]});
      send(wv[i].d[0], wv[i].d[1], wv[i].d[2], W, 0);
      check($sformatf("word%0d_valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("word%0d_index", i), O_word_index, wv[i].idx);
      if (i == 0) check("word_valid_latency", valid_cyc - last_rise, 4);
    end
    for (int i = 0; i < 7; i++) begin
      n0 = ni_cnt;
      for (int k = 0; k < cv[i].n; k++) shift(cv[i].bit_v);
      latch();
      check($sformatf("col%0d_value", i), O_column, cv[i].col);
      check($sformatf("col%0d_index", i), O_column_index, cv[i].idx);
      check($sformatf("col%0d_valid", i), O_column_valid, cv[i].vld);
      check($sformatf("col%0d_new_image", i), ni_cnt - n0, cv[i].ni);
      check($sformatf("col%0d_word_index", i), O_word_index, 0);
    end
    for (int k = 0; k < 16; k++) shift(0);
    shift(1);
    shift(0);
    shift(0);
    I_ser_data = 0;
    tick(3);
    I_ser_clk = 1;
    I_ser_stcp = 1;
    tick(4);
    I_ser_clk = 0;
    I_ser_stcp = 0;
    tick(4);
    check("simul_latch_pre_shift", O_column, 16'h0004);
    latch();
    check("simul_shift_applied", O_column, 16'h0008);
    exp_q.push_back({24'h000111, 24'h00F00F, 24'h3C3C3C});
    send(24'h3C3C3C, 24'h00F00F, 24'h000111, W, 1);
    check("latch_with_word_index", O_word_index, 1);
    stale = 10'h2B5;
    nw = 24'h00FF00;
    v0 = valid_cnt;
    f0 = fe_cnt;
    send({stale, 14'h0}, 0, 0, 10, 0);
    tick(300);
    check("partial_no_valid", valid_cnt - v0, 0);
    check("frame_error_pulses", fe_cnt - f0, TO_EN);
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
    check("frame_error_delay", (fe_cyc - last_edge >= 256 && fe_cyc - last_edge <= 260) ? 1 : 0, 1);
    exp_q.push_back({48'h0, nw});
`else
    exp_q.push_back({48'h0, stale, nw[W-1:10]});
`endif
    send(nw, 0, 0, W, 0);
    check("after_partial_valid", valid_cnt - v0, 1);
    send(24'hFFF000, 24'hABC000, 24'h123000, 12, 0);
    reset_pulse(1);
    v0 = valid_cnt;
    exp_q.push_back({24'h000001, 24'h0F0F0F, 24'h5A5A5A});
    send(24'h5A5A5A, 24'h0F0F0F, 24'h000001, W, 0);
    check("post_reset_valid", valid_cnt - v0, 1);
    check("post_reset_index", O_word_index, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
